serial_mag_cmp_ctrl: RTL

//  Sequential magnitude comparator for WIDTH-bit unsigned operands, built by sequencing one
//  2-bit GT/EQ/LT comparator slice over the operands MSB-first, one slice per cycle.

---
 rtl/cmp_pkg.sv | 10 +
 rtl/cmp2_slice.sv | 16 +
 rtl/serial_mag_cmp_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types for the serial magnitude comparator (FSM states, slice width, result flags)
package cmp_pkg;
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
    localparam int SLICE_W = 2;
    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } res_t;
endpackage

// File: rtl/cmp2_slice.sv
// cmp2_slice: combinational 2-bit unsigned compare in sum-of-products form
//   a, b : 2-bit operand slices
//   r    : {gt, eq, lt} of a versus b, exactly one-hot
module cmp2_slice
    import cmp_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    output res_t       r
);
    always_comb begin
        r.gt = (a[1] & ~b[1]) | (a[0] & ~b[1] & ~b[0]) | (a[1] & a[0] & ~b[0]);
        r.lt = (~a[1] & b[1]) | (~a[1] & ~a[0] & b[0]) | (~a[0] & b[1] & b[0]);
        r.eq = (a[1] ~^ b[1]) & (a[0] ~^ b[0]);
    end
endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// serial_mag_cmp_ctrl: MSB-first serial magnitude compare, one 2-bit slice per cycle, early exit
//   clk, reset     : clock, synchronous active-high reset
//   start          : request compare, accepted only in IDLE; inA/inB sampled then
//   busy           : high while comparing
//   done           : one-cycle pulse when outGT/outEQ/outLT/slices_used are updated
//   outGT/EQ/LT    : one-hot result, held until the next completion
//   slices_used    : slices examined for the last result
module serial_mag_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [WIDTH-1:0]                      inA,
    input  logic [WIDTH-1:0]                      inB,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  outGT,
    output logic                                  outEQ,
    output logic                                  outLT,
    output logic [$clog2(WIDTH/SLICE_W+1)-1:0]    slices_used
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam int SUW    = $clog2(NSLICE + 1);

    state_t           state;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    res_t             sr;

    cmp2_slice u_slice (
        .a(sa[WIDTH-1 -: SLICE_W]),
        .b(sb[WIDTH-1 -: SLICE_W]),
        .r(sr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            outGT       <= 1'b0;
            outEQ       <= 1'b0;
            outLT       <= 1'b0;
            slices_used <= '0;
            sa          <= '0;
            sb          <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa    <= inA;
                    sb    <= inB;
                    cnt   <= CW'(NSLICE - 1);
                    busy  <= 1'b1;
                    state <= COMPARE;
                end
                COMPARE: begin
                    // cnt counts remaining slices, so NSLICE-cnt is the 1-based slice index
                    if (!sr.eq || cnt == '0) begin
                        outGT       <= sr.gt;
                        outEQ       <= sr.eq;
                        outLT       <= sr.lt;
                        slices_used <= SUW'(NSLICE) - SUW'(cnt);
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        sa  <= sa << SLICE_W;
                        sb  <= sb << SLICE_W;
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
